// File: rtl/ps2_pkg.sv
// Shared PS/2 host definitions: FSM state encoding, frame edge indices, command bytes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package ps2_pkg;

    // Common keyboard command / response bytes
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Zero-based falling-edge index (edges already seen) at which each frame field is driven
    localparam logic [3:0] PS2_PARITY_EDGE_IDX = 4'd8;
    localparam logic [3:0] PS2_STOP_EDGE_IDX   = 4'd9;

    // Host transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    // Odd parity bit for a PS/2 byte: 1 when the byte has an even number of ones
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a one-cycle falling-edge strobe.
// Latency: 2 core cycles line->sync_o; fall_o asserts the cycle sync_o first reads low.
// Backpressure: none; free-running, flops reset to 1 (idle line level).
`timescale 1ns/1ps
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic line_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Shift the raw line through the metastability pair and keep one cycle of history
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 8 data + parity + stop, ACK read.
// Latency: INHIBIT_CYCLES + one REQ cycle + 11 device clocks + return-to-idle; done 1 cycle after lines idle.
// Backpressure: txStart is accepted only while busy=0; requests during a transfer are dropped.
`timescale 1ns/1ps
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       psClk_in,
    input  logic       psData_in,
    output logic       psClk_oe,
    output logic       psData_oe,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    output logic       timeoutErr
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    // Data is pulled low one cycle before the clock is released, so it is already
    // asserted on the final inhibit cycle; with a single inhibit cycle it is set at accept.
    localparam bit               INH_ONE  = (INHIBIT_CYCLES <= 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e       state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       edge_cnt_q, edge_cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             parity_q, parity_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;

    logic             clk_s;
    logic             clk_fall;
    logic             data_s;
    logic             data_fall_unused;
    logic             to_active;
    logic             to_expired;

    ps2_line_sync u_clk_sync (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .line_i  (psClk_in),
        .sync_o  (clk_s),
        .fall_o  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk_i   (Clk),
        .rst_n_i (Reset_n),
        .line_i  (psData_in),
        .sync_o  (data_s),
        .fall_o  (data_fall_unused)
    );

    // Transfer watchdog runs from the request-to-send until the bus returns idle
    always_comb begin
        to_active  = (state_q == ST_REQ) || (state_q == ST_SHIFT) ||
                     (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
        to_expired = to_active && (to_cnt_q == TO_LAST);
    end

    // Next-state and datapath decisions for the transmit sequence
    always_comb begin
        state_d    = state_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_byte_d  = tx_byte_q;
        parity_d   = parity_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        timeout_d  = 1'b0;

        if (to_active) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (txStart) begin
                    tx_byte_d  = txData;
                    parity_d   = odd_parity(txData);
                    busy_d     = 1'b1;
                    ack_err_d  = 1'b0;
                    inh_cnt_d  = '0;
                    edge_cnt_d = '0;
                    clk_oe_d   = 1'b1;
                    data_oe_d  = INH_ONE;
                    state_d    = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                if (!INH_ONE && (inh_cnt_q == INH_PRE)) begin
                    data_oe_d = 1'b1;
                end
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = ST_REQ;
                end
            end

            // Clock just released with data low: the device now owns the clock
            ST_REQ: begin
                state_d = ST_SHIFT;
            end

            // Each device falling edge presents the next bit while the clock is low
            ST_SHIFT: begin
                if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    if (edge_cnt_q < PS2_PARITY_EDGE_IDX) begin
                        data_oe_d = ~tx_byte_q[edge_cnt_q[2:0]];
                    end else if (edge_cnt_q == PS2_PARITY_EDGE_IDX) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                end
            end

            // Device drives its ACK bit; low means the byte was accepted
            ST_ACK: begin
                if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    ack_err_d  = data_s;
                    state_d    = ST_WAIT_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        // A stuck or absent device: let go of the bus and report, never as done
        if (to_expired) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            ack_err_d = ack_err_q;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    // State and output registers; reset releases both lines immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            edge_cnt_q <= '0;
            tx_byte_q  <= '0;
            parity_q   <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_byte_q  <= tx_byte_d;
            parity_q   <= parity_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign psClk_oe   = clk_oe_q;
    assign psData_oe  = data_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ackErr     = ack_err_q;
    assign timeoutErr = timeout_q;

    // Completion and abort are exclusive outcomes of one transfer
    a_done_xor_timeout: assert property (@(posedge Clk) disable iff (!Reset_n) !(done && timeoutErr));

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 8;
    localparam int TMO  = 4000;
    localparam int HALF = 100;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       psClk_in, psData_in;
    logic       psClk_oe, psData_oe;
    logic [7:0] txData = 8'h00;
    logic       txStart = 1'b0;
    logic       busy, done, ackErr, timeoutErr;

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    int cyc = 0;
    int acc = -100000;
    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;
    int dev_edges = 0;
    logic prev_d = 1'b0;
    bit   prev_ok = 1'b0;

    // Open-drain bus with pull-ups
    assign psClk_in  = ~(psClk_oe | dev_clk_low);
    assign psData_in = ~(psData_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .psClk_in   (psClk_in),
        .psData_in  (psData_in),
        .psClk_oe   (psClk_oe),
        .psData_oe  (psData_oe),
        .txData     (txData),
        .txStart    (txStart),
        .busy       (busy),
        .done       (done),
        .ackErr     (ackErr),
        .timeoutErr (timeoutErr)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Frame the device must see: [7:0] byte LSB first, [8] odd parity, [9] stop=1
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
    endfunction

    // Per-cycle comparison against the timing model
    always @(negedge Clk) begin
        if (!Reset_n) begin
            prev_ok = 1'b0;
        end else begin
            check("done_tmo_excl", 32'(done & timeoutErr), 32'd0);
            check("clk_oe_window", 32'(psClk_oe), 32'((cyc >= acc + 1) && (cyc <= acc + INH)));
            if ((cyc >= acc + 1) && (cyc <= acc + INH + 1))
                check("data_oe_request", 32'(psData_oe), 32'(cyc >= acc + INH));
            if (prev_ok && (psData_oe !== prev_d) && !timeoutErr)
                check("data_oe_chg_clk_low", 32'(psClk_in), 32'd0);
            if (done) done_cnt++;
            if (timeoutErr) tmo_cnt++;
            prev_d  = psData_oe;
            prev_ok = 1'b1;
        end
    end

    task automatic start_tx(input logic [7:0] b);
        @(negedge Clk);
        txData    = b;
        txStart   = 1'b1;
        acc       = cyc;
        dev_edges = 0;
        @(negedge Clk);
        txStart = 1'b0;
    endtask

    // Device: wait for request-to-send, then clock 11 bits at 200-cycle period
    task automatic device_frame(input logic ack_bit, input int abort_at,
                                output logic [9:0] bits, output bit ok);
        int t;
        ok = 1'b0;
        bits = '0;
        t = 0;
        while (!(psClk_oe == 1'b0 && psData_oe == 1'b1) && t < 200) begin
            @(negedge Clk);
            t++;
        end
        check("req_seen", 32'(t < 200), 32'd1);
        if (t >= 200) return;
        repeat (40) @(negedge Clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            dev_edges++;
            if (k == abort_at) begin
                repeat (20) @(negedge Clk);
                ok = 1'b1;
                return;
            end
            repeat (HALF) @(negedge Clk);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = psData_in;
            if (k == 10) dev_data_low = ~ack_bit;
            if (k == 11) begin
                dev_data_low = 1'b0;
                ok = 1'b1;
                return;
            end
            repeat (HALF) @(negedge Clk);
        end
        ok = 1'b1;
    endtask

    task automatic run_tx(input logic [7:0] b, input logic ack_bit, input logic [9:0] lit, input bit inject);
        logic [9:0] got;
        bit ok;
        int t;
        int d0;
        d0 = done_cnt;
        start_tx(b);
        if (inject) begin
            fork
                device_frame(ack_bit, 0, got, ok);
                begin
                    int w;
                    w = 0;
                    while (dev_edges < 3 && w < 3000) begin
                        @(negedge Clk);
                        w++;
                    end
                    txData  = PS2_CMD_RESET;
                    txStart = 1'b1;
                    @(negedge Clk);
                    txStart = 1'b0;
                end
            join
        end else begin
            device_frame(ack_bit, 0, got, ok);
        end
        check("frame_ok", 32'(ok), 32'd1);
        check("frame_model", 32'(got), 32'(model_frame(b)));
        check("frame_literal", 32'(got), 32'(lit));
        t = 0;
        while (!done && t < 50) begin
            @(negedge Clk);
            t++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("ackErr_at_done", 32'(ackErr), 32'(ack_bit));
        check("tmo_quiet", 32'(timeoutErr), 32'd0);
        @(negedge Clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt), 32'(d0 + 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [9:0] got;
        bit ok;
        int tmo_at;
        int d0;
        int t0;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_clk_oe", 32'(psClk_oe), 32'd0);
        check("rst_data_oe", 32'(psData_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ackErr", 32'(ackErr), 32'd0);
        check("rst_timeoutErr", 32'(timeoutErr), 32'd0);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);

        // Set-LEDs command, ACKed
        run_tx(PS2_CMD_SET_LEDS, 1'b0, 10'h3ED, 1'b0);
        repeat (20) @(negedge Clk);

        // All-zero byte: parity 1, device NACKs
        run_tx(8'h00, 1'b1, 10'h300, 1'b0);
        repeat (50) @(negedge Clk);
        check("ackErr_hold", 32'(ackErr), 32'd1);

        // Start during SHIFT is ignored; ackErr clears on the accepted start
        fork
            run_tx(PS2_CMD_SET_LEDS, 1'b0, 10'h3ED, 1'b1);
            begin
                @(negedge Clk);
                @(negedge Clk);
                check("ackErr_cleared", 32'(ackErr), 32'd0);
                check("busy_after_start", 32'(busy), 32'd1);
            end
        join
        repeat (20) @(negedge Clk);

        // Silent device: timeout 4000 cycles after the request cycle
        d0 = done_cnt;
        start_tx(PS2_CMD_SET_LEDS);
        tmo_at = -1;
        for (int i = 0; i < 4200 && tmo_at < 0; i++) begin
            @(negedge Clk);
            if (timeoutErr) begin
                tmo_at = cyc;
                check("tmo_clk_oe", 32'(psClk_oe), 32'd0);
                check("tmo_data_oe", 32'(psData_oe), 32'd0);
                check("tmo_busy", 32'(busy), 32'd0);
            end
        end
        check("tmo_cycle", 32'(tmo_at), 32'(acc + INH + 1 + TMO));
        @(negedge Clk);
        check("tmo_one_cycle", 32'(timeoutErr), 32'd0);
        check("tmo_no_done", 32'(done_cnt), 32'(d0));
        repeat (20) @(negedge Clk);

        // Reset after the 5th falling edge
        start_tx(PS2_CMD_SET_LEDS);
        device_frame(1'b0, 5, got, ok);
        check("rst_mid_reached", 32'(ok), 32'd1);
        check("busy_before_rst", 32'(busy), 32'd1);
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        check("rst_mid_clk_oe", 32'(psClk_oe), 32'd0);
        check("rst_mid_data_oe", 32'(psData_oe), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        dev_clk_low = 1'b0;
        repeat (4) @(negedge Clk);
        Reset_n = 1'b1;
        d0 = done_cnt;
        t0 = tmo_cnt;
        repeat (300) @(negedge Clk);
        check("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        check("rst_mid_no_tmo", 32'(tmo_cnt), 32'(t0));
        check("rst_mid_idle", 32'(busy), 32'd0);

        // Fresh transfer after reset
        run_tx(PS2_CMD_RESET, 1'b0, 10'h3FF, 1'b0);
        repeat (20) @(negedge Clk);

        check("total_done", 32'(done_cnt), 32'd4);
        check("total_tmo", 32'(tmo_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
